// File: rtl/rem_sym_scheduler.sv
// rem_sym_scheduler: for each symbol of a slot, walks the allocated
// subcarriers of the FFT symbol memory once. For DMRS symbols it also walks
// the DMRS memory. It waits for a free downstream ping-pong half before each
// symbol. Every output is registered and decoded from the next-state values,
// so the outputs line up with the state that produces them.
module rem_sym_scheduler #(
    parameter int ADDR_W      = 11,
    parameter int DMRS_ADDR_W = 10
) (
    input  logic                   CLK_RE,
    input  logic                   RST_RE,
    input  logic                   Start,
    input  logic                   Abort,
    input  logic [ADDR_W-1:0]      N_sc,
    input  logic [6:0]             N_rb,
    input  logic [3:0]             Sym_Start,
    input  logic [3:0]             Sym_End,
    input  logic [13:0]            Dmrs_Map,
    input  logic                   Buf_Free,
    output logic [ADDR_W-1:0]      Rd_addr,
    output logic [DMRS_ADDR_W-1:0] Dmrs_addr,
    output logic                   Rd_Valid,
    output logic                   Src_Sel,
    output logic [3:0]             Sym_Idx,
    output logic                   Sym_Done,
    output logic                   RE_Done,
    output logic                   Busy,
    output logic                   Cfg_Err
);

    // RE counter width; the largest legal allocation is 85 RB * 12 = 1020 REs.
    localparam int K_W       = 12;
    // Wide enough that N_sc + 12*N_rb cannot wrap before the range check.
    localparam int SUM_W     = (ADDR_W + 1 > K_W) ? ADDR_W + 1 : K_W;
    localparam int MAX_RB    = 85;
    localparam int SC_PER_RB = 12;
    localparam int LAST_SYM  = 13;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BUF,
        STREAM,
        SYM_END,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [K_W-1:0]   k_q, k_d;
    logic [3:0]       sym_q, sym_d;

    // Slot configuration captured on an accepted Start.
    logic [ADDR_W-1:0] cfg_n_sc;
    logic [K_W-1:0]    cfg_last_k;
    logic [3:0]        cfg_sym_end;
    logic [13:0]       cfg_dmrs_map;
    logic              load_cfg;

    logic [SUM_W-1:0]  re_count;
    logic              cfg_bad;

    logic [ADDR_W-1:0]      rd_addr_d;
    logic [DMRS_ADDR_W-1:0] dmrs_addr_d;
    logic                   rd_valid_d;
    logic                   src_sel_d;
    logic [3:0]             sym_idx_d;
    logic                   sym_done_d;
    logic                   re_done_d;
    logic                   busy_d;
    logic                   cfg_err_d;

    // Validate the requested allocation before it is allowed to start a slot.
    always_comb begin
        re_count = SUM_W'(N_rb) * SUM_W'(SC_PER_RB);
        cfg_bad  = (N_rb == 7'd0)
                || (N_rb > 7'(MAX_RB))
                || (Sym_Start > Sym_End)
                || (Sym_End > 4'(LAST_SYM))
                || ((SUM_W'(N_sc) + re_count) > SUM_W'(2 ** ADDR_W));
    end

    // Next-state logic followed by decode of the registered outputs.
    always_comb begin
        // NOTE: every signal gets a default before the case statement, so no
        // path through this block can leave a value unassigned and infer a latch.
        state_d     = state_q;
        k_d         = k_q;
        sym_d       = sym_q;
        load_cfg    = 1'b0;
        cfg_err_d   = 1'b0;
        rd_valid_d  = 1'b0;
        rd_addr_d   = '0;
        dmrs_addr_d = '0;
        src_sel_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (Start && !Abort) begin
                    if (cfg_bad) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        load_cfg = 1'b1;
                        sym_d    = Sym_Start;
                        k_d      = '0;
                        state_d  = WAIT_BUF;
                    end
                end
            end
            WAIT_BUF: begin
                if (Buf_Free) begin
                    k_d     = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (k_q == cfg_last_k) begin
                    state_d = SYM_END;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            SYM_END: begin
                if (sym_q == cfg_sym_end) begin
                    state_d = DONE;
                end else begin
                    sym_d   = sym_q + 4'd1;
                    state_d = WAIT_BUF;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort beats every other transition, including a Start in IDLE.
        if (Abort) begin
            state_d   = IDLE;
            cfg_err_d = 1'b0;
            load_cfg  = 1'b0;
        end

        if (state_d == STREAM) begin
            rd_valid_d = 1'b1;
            rd_addr_d  = ADDR_W'(SUM_W'(cfg_n_sc) + SUM_W'(k_d));
            src_sel_d  = cfg_dmrs_map[sym_d];
            if (src_sel_d) begin
                dmrs_addr_d = k_d[DMRS_ADDR_W-1:0];
            end
        end
        sym_done_d = (state_d == SYM_END);
        re_done_d  = (state_d == DONE);
        busy_d     = (state_d != IDLE);
        sym_idx_d  = busy_d ? sym_d : 4'd0;
    end

    // State, counters and registered outputs.
    always_ff @(posedge CLK_RE or posedge RST_RE) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge value of every other register.
        if (RST_RE) begin
            state_q   <= IDLE;
            k_q       <= '0;
            sym_q     <= '0;
            Rd_addr   <= '0;
            Dmrs_addr <= '0;
            Rd_Valid  <= 1'b0;
            Src_Sel   <= 1'b0;
            Sym_Idx   <= '0;
            Sym_Done  <= 1'b0;
            RE_Done   <= 1'b0;
            Busy      <= 1'b0;
            Cfg_Err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            sym_q     <= sym_d;
            Rd_addr   <= rd_addr_d;
            Dmrs_addr <= dmrs_addr_d;
            Rd_Valid  <= rd_valid_d;
            Src_Sel   <= src_sel_d;
            Sym_Idx   <= sym_idx_d;
            Sym_Done  <= sym_done_d;
            RE_Done   <= re_done_d;
            Busy      <= busy_d;
            Cfg_Err   <= cfg_err_d;
        end
    end

    // Capture the slot configuration on an accepted Start.
    always_ff @(posedge CLK_RE) begin
        // NOTE: these registers carry no reset because nothing reads them
        // before an accepted Start has written them.
        if (load_cfg) begin
            cfg_n_sc     <= N_sc;
            cfg_last_k   <= K_W'(re_count - SUM_W'(1));
            cfg_sym_end  <= Sym_End;
            cfg_dmrs_map <= Dmrs_Map;
        end
    end

endmodule

// File: tb/tb_rem_sym_scheduler.sv
// tb_rem_sym_scheduler: directed stimulus pushes the expected output events
// into a queue. A negedge monitor pops and compares each event the DUT presents.
module tb_rem_sym_scheduler;

    typedef enum logic [1:0] {
        EV_RE,
        EV_SYM_DONE,
        EV_RE_DONE,
        EV_CFG_ERR
    } ev_kind_t;

    typedef struct packed {
        ev_kind_t    kind;
        logic [10:0] rd_addr;
        logic [9:0]  dmrs_addr;
        logic        src_sel;
        logic [3:0]  sym_idx;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [10:0] n_sc;
    logic [6:0]  n_rb;
    logic [3:0]  sym_start;
    logic [3:0]  sym_end;
    logic [13:0] dmrs_map;
    logic        buf_free;

    logic [10:0] rd_addr;
    logic [9:0]  dmrs_addr;
    logic        rd_valid;
    logic        src_sel;
    logic [3:0]  sym_idx;
    logic        sym_done;
    logic        re_done;
    logic        busy;
    logic        cfg_err;

    int   checks = 0;
    int   errors = 0;
    ev_t  exp_q[$];
    int   valid_cnt = 0;
    int   last_rd = 0;
    int   last_dmrs = 0;

    rem_sym_scheduler #(
        .ADDR_W      (11),
        .DMRS_ADDR_W (10)
    ) dut (
        .CLK_RE    (clk),
        .RST_RE    (rst),
        .Start     (start),
        .Abort     (abort),
        .N_sc      (n_sc),
        .N_rb      (n_rb),
        .Sym_Start (sym_start),
        .Sym_End   (sym_end),
        .Dmrs_Map  (dmrs_map),
        .Buf_Free  (buf_free),
        .Rd_addr   (rd_addr),
        .Dmrs_addr (dmrs_addr),
        .Rd_Valid  (rd_valid),
        .Src_Sel   (src_sel),
        .Sym_Idx   (sym_idx),
        .Sym_Done  (sym_done),
        .RE_Done   (re_done),
        .Busy      (busy),
        .Cfg_Err   (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, req);
        end
    endtask

    task automatic observe(input ev_t act);
        ev_t req;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_unexpected actual kind=%0d rd=%0d dmrs=%0d src=%0b sym=%0d required none",
                     act.kind, act.rd_addr, act.dmrs_addr, act.src_sel, act.sym_idx);
        end else begin
            req = exp_q.pop_front();
            if (act !== req) begin
                errors++;
                $display("FAIL scoreboard actual kind=%0d rd=%0d dmrs=%0d src=%0b sym=%0d required kind=%0d rd=%0d dmrs=%0d src=%0b sym=%0d",
                         act.kind, act.rd_addr, act.dmrs_addr, act.src_sel, act.sym_idx,
                         req.kind, req.rd_addr, req.dmrs_addr, req.src_sel, req.sym_idx);
            end
        end
    endtask

    // Monitor: every presented RE or pulse is one scoreboard comparison.
    always @(negedge clk) begin
        ev_t a;
        if (!rst) begin
            if (rd_valid) begin
                a = '0;
                a.kind      = EV_RE;
                a.rd_addr   = rd_addr;
                a.dmrs_addr = dmrs_addr;
                a.src_sel   = src_sel;
                a.sym_idx   = sym_idx;
                valid_cnt++;
                last_rd   = int'(rd_addr);
                last_dmrs = int'(dmrs_addr);
                observe(a);
            end
            if (sym_done) begin
                a = '0;
                a.kind    = EV_SYM_DONE;
                a.sym_idx = sym_idx;
                observe(a);
            end
            if (re_done) begin
                a = '0;
                a.kind    = EV_RE_DONE;
                a.sym_idx = sym_idx;
                observe(a);
            end
            if (cfg_err) begin
                a = '0;
                a.kind    = EV_CFG_ERR;
                a.sym_idx = sym_idx;
                observe(a);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input ev_kind_t kind, input int sym);
        ev_t e;
        e = '0;
        e.kind    = kind;
        e.sym_idx = 4'(sym);
        exp_q.push_back(e);
    endtask

    // Expected REs of one symbol, the first 'count' of them.
    task automatic push_res(input int nsc, input int sym, input logic dmrs, input int count);
        ev_t e;
        for (int k = 0; k < count; k++) begin
            e = '0;
            e.kind      = EV_RE;
            e.rd_addr   = 11'(nsc + k);
            e.dmrs_addr = dmrs ? 10'(k) : 10'd0;
            e.src_sel   = dmrs;
            e.sym_idx   = 4'(sym);
            exp_q.push_back(e);
        end
    endtask

    task automatic push_slot(input int nsc, input int nrb, input int s0, input int s1,
                             input logic [13:0] map);
        for (int s = s0; s <= s1; s++) begin
            push_res(nsc, s, map[s], 12 * nrb);
            push_ev(EV_SYM_DONE, s);
        end
        push_ev(EV_RE_DONE, s1);
    endtask

    task automatic start_slot(input int nsc, input int nrb, input int s0, input int s1,
                              input logic [13:0] map);
        n_sc      = 11'(nsc);
        n_rb      = 7'(nrb);
        sym_start = 4'(s0);
        sym_end   = 4'(s1);
        dmrs_map  = map;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check(name, int'(busy || exp_q.size() != 0), 0);
    endtask

    task automatic cfg_err_case(input string name, input int nsc, input int nrb,
                                input int s0, input int s1);
        push_ev(EV_CFG_ERR, 0);
        start_slot(nsc, nrb, s0, s1, 14'h0);
        check(name, int'(busy), 0);
        tick();
        check(name, int'(busy), 0);
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        n_sc      = '0;
        n_rb      = '0;
        sym_start = '0;
        sym_end   = '0;
        dmrs_map  = '0;
        buf_free  = 1'b0;

        // Reset state: every output is zero.
        #2;
        check("reset_outputs",
              int'({rd_addr, dmrs_addr, sym_idx, rd_valid, src_sel, sym_done, re_done, busy, cfg_err}), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // Nominal two-symbol slot, DMRS on symbol 2 only.
        buf_free  = 1'b1;
        valid_cnt = 0;
        push_slot(100, 2, 2, 3, 14'h0004);
        start_slot(100, 2, 2, 3, 14'h0004);
        wait_idle("nominal_done", 200);
        check("nominal_valid_count", valid_cnt, 48);

        // Backpressure: ten cycles of Buf_Free low, then one-cycle latency.
        // A second Start during the wait must be ignored.
        buf_free = 1'b0;
        push_slot(0, 1, 5, 5, 14'h0);
        start_slot(0, 1, 5, 5, 14'h0);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                n_sc  = 11'd500;
                start = 1'b1;
            end
            tick();
            start = 1'b0;
            n_sc  = 11'd0;
            check("bp_hold_valid", int'(rd_valid), 0);
            check("bp_hold_busy_sym", int'({busy, sym_idx}), 16 + 5);
        end
        buf_free = 1'b1;
        tick();
        check("bp_first_valid", int'(rd_valid), 1);
        wait_idle("bp_done", 100);

        // Rejected configurations.
        cfg_err_case("cfg_nsc_overflow", 2000, 5, 0, 0);
        cfg_err_case("cfg_nrb_zero", 0, 0, 0, 0);
        cfg_err_case("cfg_sym_order", 0, 1, 5, 4);
        cfg_err_case("cfg_nrb_86", 0, 86, 0, 0);
        cfg_err_case("cfg_sym_end_14", 0, 1, 0, 14);

        // Start and Abort together in IDLE: nothing starts.
        abort = 1'b1;
        start_slot(0, 1, 0, 0, 14'h0);
        abort = 1'b0;
        check("start_abort_idle", int'(busy), 0);
        repeat (3) tick();
        check("start_abort_no_events", exp_q.size(), 0);

        // Abort while the RE with k=7 is presented.
        push_res(200, 0, 1'b1, 8);
        start_slot(200, 1, 0, 0, 14'h0001);
        repeat (8) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy_low", int'(busy), 0);
        check("abort_valid_low", int'(rd_valid), 0);
        repeat (5) tick();
        check("abort_no_pulses", exp_q.size(), 0);
        push_slot(100, 2, 2, 3, 14'h0004);
        start_slot(100, 2, 2, 3, 14'h0004);
        wait_idle("after_abort_done", 200);

        // Reset pulse mid-slot after the RE with k=4 has been observed.
        push_res(300, 7, 1'b0, 5);
        start_slot(300, 1, 7, 7, 14'h0);
        repeat (5) tick();
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("midreset_outputs",
              int'({rd_addr, dmrs_addr, sym_idx, rd_valid, src_sel, sym_done, re_done, busy, cfg_err}), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) tick();
        check("midreset_busy", int'(busy), 0);
        check("midreset_no_pulses", exp_q.size(), 0);

        // Boundary allocation: top of the symbol memory, DMRS on symbol 13.
        valid_cnt = 0;
        push_slot(1024, 85, 13, 13, 14'h2000);
        start_slot(1024, 85, 13, 13, 14'h2000);
        wait_idle("boundary_done", 1200);
        check("boundary_valid_count", valid_cnt, 1020);
        check("boundary_last_rd", last_rd, 2043);
        check("boundary_last_dmrs", last_dmrs, 1019);

        tick();
        check("final_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rem_sym_scheduler.md
REM_SYM_SCHEDULER -- requirements
Module: rem_sym_scheduler

Interface
REQ-001 Parameter: ADDR_W, default 11, FFT symbol-memory address width (2048 entries).
REQ-002 Parameter: DMRS_ADDR_W, default 10, DMRS memory address width (1024 entries).
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, with ports named as follows.
REQ-004 CLK_RE  input  1  sole clock, rising edge.
REQ-005 RST_RE  input  1  asynchronous, active-high reset.
REQ-006 Start  input  1  one-cycle pulse that begins a slot.
REQ-007 Abort  input  1  synchronous abort.
REQ-008 N_sc  input  11  first subcarrier index.
REQ-009 N_rb  input  7  number of allocated resource blocks.
REQ-010 Sym_Start / Sym_End  input  4 each  first and last symbol index, inclusive.
REQ-011 Dmrs_Map  input  14  bit s=1 means symbol s carries DMRS.
REQ-012 Buf_Free  input  1  downstream ping-pong half is ready to accept a symbol.
REQ-013 Rd_addr  output  11  FFT memory read address.
REQ-014 Dmrs_addr  output  10  DMRS memory read address.
REQ-015 Rd_Valid  output  1  Rd_addr and Dmrs_addr are valid this cycle.
REQ-016 Src_Sel  output  1  1 = DMRS symbol, 0 = data symbol.
REQ-017 Sym_Idx  output  4  current symbol index.
REQ-018 Sym_Done  output  1  one-cycle pulse at end of each symbol.
REQ-019 RE_Done  output  1  one-cycle pulse at end of the slot.
REQ-020 Busy  output  1  high in every state except IDLE.
REQ-021 Cfg_Err  output  1  one-cycle pulse on a rejected Start.

Function
REQ-022 FSM states: IDLE, WAIT_BUF, STREAM, SYM_END, DONE; all outputs are registered.
REQ-023 IDLE + Start: latch N_sc, N_rb, Sym_Start, Sym_End and Dmrs_Map; set sym = Sym_Start; go to WAIT_BUF.
REQ-024 A Start is rejected when any of these holds: N_rb==0, N_rb>85, Sym_Start>Sym_End, Sym_End>13, or N_sc+12*N_rb>2048.
REQ-025 On a rejected Start: pulse Cfg_Err for 1 cycle, remain in IDLE, latch nothing.
REQ-026 Start is ignored while Busy is high.
REQ-027 WAIT_BUF: hold while Buf_Free==0; on Buf_Free==1, go to STREAM with k=0.
REQ-028 Latency: Rd_Valid first goes high in the cycle after Buf_Free is sampled high.
REQ-029 STREAM issues one RE per cycle with no gaps:
- Rd_Valid=1
- Rd_addr = N_sc + k
- k runs 0..12*N_rb-1
- 12-bit k; the sum is computed at 12 bits and the result fits in 11 bits after the range check.
REQ-030 In STREAM, Src_Sel = Dmrs_Map[sym].
REQ-031 In STREAM, Dmrs_addr = k[9:0] when Src_Sel==1; otherwise Dmrs_addr holds 0.
REQ-032 After the RE with k = 12*N_rb-1, go to SYM_END; Rd_Valid drops in the SYM_END cycle.
REQ-033 SYM_END: pulse Sym_Done for 1 cycle.
- If sym==Sym_End, go to DONE.
- Otherwise increment sym and go to WAIT_BUF.
REQ-034 DONE: pulse RE_Done for 1 cycle, then go to IDLE.
REQ-035 Abort in any non-IDLE state: go to IDLE next cycle; drop Rd_Valid; pulse neither Sym_Done nor RE_Done.
REQ-036 Abort has priority over every other transition.
REQ-037 Start and Abort asserted in the same cycle while in IDLE: Abort wins, no slot starts.
REQ-038 Buf_Free changes during STREAM are ignored; Buf_Free is sampled only in WAIT_BUF.
REQ-039 Sym_Idx shows sym continuously while Busy is high.

Reset
REQ-040 While RST_RE is high:
- the FSM is in IDLE
- k=0 and sym=0
- Rd_addr=0, Dmrs_addr=0, Sym_Idx=0
- Rd_Valid, Src_Sel, Sym_Done, RE_Done, Busy and Cfg_Err are all 0.
REQ-041 Reset asserted mid-slot aborts immediately; no done pulses are produced; after release the block waits for a new Start.

Verification
REQ-042 Nominal: N_sc=100, N_rb=2, Sym 2..3, Dmrs_Map bit2, Buf_Free=1 -> expected response:
- sym2: Rd_addr 100..123 over 24 consecutive cycles, Src_Sel=1, Dmrs_addr 0..23
- Sym_Done pulse
- sym3: Rd_addr 100..123 again, Src_Sel=0
- Sym_Done pulse, then RE_Done pulse.
REQ-043 Backpressure: Buf_Free held 0 for 10 cycles in WAIT_BUF -> Rd_Valid stays 0; first valid RE appears 1 cycle after Buf_Free rises.
REQ-044 Config errors -> Cfg_Err pulse, Busy stays 0, in each case:
- N_sc=2000 with N_rb=5
- N_rb=0
- Sym_Start=5 with Sym_End=4
REQ-045 Abort in the middle of STREAM at k=7 -> Busy low on the next cycle; no Sym_Done or RE_Done; a following valid Start runs normally.
REQ-046 RST_RE pulsed mid-slot -> every output is 0 asynchronously; no pulses after release.
REQ-047 Boundary: N_sc=1024, N_rb=85, single symbol 13 with DMRS -> expected response:
- last Rd_addr=2043
- last Dmrs_addr=1019
- exactly 1020 valid cycles.
